// File: rtl/taxi_qsfp_port_mgr.sv
// QSFP cage sideband manager: presence debounce, ResetL/LPMode sequencing and
// IntL latching per cage, plus a round-robin one-hot ModSelL/I2C arbiter.
module taxi_qsfp_port_lane #(
  parameter int DEBOUNCE_CYC = 125000,
  parameter int RESET_CYC    = 1250,
  parameter int INIT_CYC     = 250000000,
  parameter int CNT_W        = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic modprsl_i,
  input  logic intl_i,
  input  logic cfg_lpmode_i,
  input  logic sw_reset_req_i,
  input  logic int_clear_i,
  output logic resetl_o,
  output logic lpmode_o,
  output logic present_o,
  output logic ready_o,
  output logic int_o
);
  typedef enum logic [1:0] {ABSENT, RESET, INIT, READY} state_e;

  localparam logic [CNT_W-1:0] DBC_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYC - 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYC - 1);

  state_e           state_q, state_d;
  logic [2:0]       prs_q;        // [1:0] synchroniser, [2] previous synced sample
  logic [1:0]       intl_q;
  logic [CNT_W-1:0] dbc_q, dbc_d, tmr_q, tmr_d;
  logic             present_q, present_d, resetl_q, lpmode_q, int_q, int_d, restart;

  always_comb begin
    dbc_d     = '0;
    present_d = present_q;
    // count only while the synced pin is stable and disagrees with stat_present
    if (prs_q[1] == prs_q[2] && prs_q[1] == present_q) begin
      if (dbc_q == DBC_LAST) present_d = ~present_q;
      else                   dbc_d     = dbc_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    case (state_q)
      ABSENT: if (present_q) state_d = RESET;
      RESET: begin
        if (sw_reset_req_i)       restart = 1'b1;
        else if (tmr_q == RST_LAST) state_d = INIT;
      end
      INIT: begin
        if (sw_reset_req_i)          state_d = RESET;
        else if (tmr_q == INIT_LAST) state_d = READY;
      end
      READY:   if (sw_reset_req_i) state_d = RESET;
      default: state_d = ABSENT;
    endcase
    if (!present_q) state_d = ABSENT;
    tmr_d = tmr_q;
    if (state_d != state_q || restart) tmr_d = '0;
    else if (~&tmr_q)                  tmr_d = tmr_q + 1'b1;

    int_d = int_q;
    if (state_q != READY || state_d != READY) int_d = 1'b0;
    else if (!intl_q[1])                       int_d = 1'b1;
    else if (int_clear_i)                      int_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prs_q     <= '1;
      intl_q    <= '1;
      dbc_q     <= '0;
      present_q <= 1'b0;
      state_q   <= ABSENT;
      tmr_q     <= '0;
      resetl_q  <= 1'b0;
      lpmode_q  <= 1'b1;
      int_q     <= 1'b0;
    end else begin
      prs_q     <= {prs_q[1:0], modprsl_i};
      intl_q    <= {intl_q[0], intl_i};
      dbc_q     <= dbc_d;
      present_q <= present_d;
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      resetl_q  <= (state_d == INIT) || (state_d == READY);
      lpmode_q  <= (state_q == READY && state_d == READY) ? cfg_lpmode_i : 1'b1;
      int_q     <= int_d;
    end
  end

  assign resetl_o  = resetl_q;
  assign lpmode_o  = lpmode_q;
  assign present_o = present_q;
  assign ready_o   = (state_q == READY);
  assign int_o     = int_q;
endmodule

module taxi_qsfp_port_mgr #(
  parameter int PORT_CNT         = 2,
  parameter int DEBOUNCE_CYC     = 125000,
  parameter int RESET_CYC        = 1250,
  parameter int INIT_CYC         = 250000000,
  parameter int MODSEL_SETUP_CYC = 250000,
  parameter int CNT_W            = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PORT_CNT-1:0] eth_port_modprsl,
  input  logic [PORT_CNT-1:0] eth_port_intl,
  output logic [PORT_CNT-1:0] eth_port_resetl,
  output logic [PORT_CNT-1:0] eth_port_lpmode,
  output logic [PORT_CNT-1:0] eth_port_modsell,
  input  logic [PORT_CNT-1:0] cfg_lpmode,
  input  logic [PORT_CNT-1:0] sw_reset_req,
  input  logic [PORT_CNT-1:0] int_clear,
  input  logic [PORT_CNT-1:0] i2c_req,
  output logic [PORT_CNT-1:0] i2c_gnt,
  output logic [PORT_CNT-1:0] stat_present,
  output logic [PORT_CNT-1:0] stat_ready,
  output logic [PORT_CNT-1:0] int_latched
);
  localparam int IDX_W = (PORT_CNT > 1) ? $clog2(PORT_CNT) : 1;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(MODSEL_SETUP_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, GRANT, RELEASE} arb_e;

  taxi_qsfp_port_lane #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC), .RESET_CYC(RESET_CYC),
    .INIT_CYC(INIT_CYC), .CNT_W(CNT_W)
  ) u_lane [PORT_CNT-1:0] (
    .clk(clk), .rst_n(rst_n),
    .modprsl_i(eth_port_modprsl), .intl_i(eth_port_intl),
    .cfg_lpmode_i(cfg_lpmode), .sw_reset_req_i(sw_reset_req), .int_clear_i(int_clear),
    .resetl_o(eth_port_resetl), .lpmode_o(eth_port_lpmode),
    .present_o(stat_present), .ready_o(stat_ready), .int_o(int_latched)
  );

  arb_e                arb_q, arb_d;
  logic [IDX_W-1:0]    sel_q, sel_d, last_q, last_d, idx;
  logic [CNT_W-1:0]    atmr_q, atmr_d;
  logic [PORT_CNT-1:0] cand, modsell_q, modsell_d, gnt_q, gnt_d;
  logic                found;

  assign cand = i2c_req & stat_ready;

  always_comb begin
    arb_d  = arb_q;
    sel_d  = sel_q;
    last_d = last_q;
    idx    = '0;
    found  = 1'b0;
    case (arb_q)
      IDLE: begin
        for (int i = 1; i <= PORT_CNT; i++) begin
          idx = IDX_W'((int'(last_q) + i) % PORT_CNT);
          if (!found && cand[idx]) begin
            found = 1'b1;
            sel_d = idx;
          end
        end
        if (found) arb_d = SETUP;
      end
      SETUP: begin
        if (!stat_ready[sel_q]) arb_d = RELEASE;
        else if (atmr_q == SETUP_LAST) begin
          arb_d  = GRANT;
          last_d = sel_q;
        end
      end
      GRANT:   if (!stat_ready[sel_q] || !i2c_req[sel_q]) arb_d = RELEASE;
      default: arb_d = IDLE;
    endcase
    atmr_d = atmr_q;
    if (arb_d != arb_q) atmr_d = '0;
    else if (~&atmr_q)  atmr_d = atmr_q + 1'b1;

    modsell_d = '1;
    gnt_d     = '0;
    if (arb_d == SETUP || arb_d == GRANT) modsell_d[sel_d] = 1'b0;
    if (arb_d == GRANT)                   gnt_d[sel_d]     = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_q     <= IDLE;
      sel_q     <= '0;
      last_q    <= IDX_W'(PORT_CNT - 1);
      atmr_q    <= '0;
      modsell_q <= '1;
      gnt_q     <= '0;
    end else begin
      arb_q     <= arb_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      atmr_q    <= atmr_d;
      modsell_q <= modsell_d;
      gnt_q     <= gnt_d;
    end
  end

  // grant is cut the same cycle the port drops out of READY
  assign i2c_gnt          = gnt_q & stat_ready;
  assign eth_port_modsell = modsell_q;
endmodule

// File: tb/tb_taxi_qsfp_port_mgr.sv
// Directed walk through the cage lifecycle plus a randomized READY-phase
// run checked against a rule-level model of lpmode and the interrupt latch.
module tb_taxi_qsfp_port_mgr;
  localparam int P = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [P-1:0] modprsl, intl, cfg_lpmode, sw_reset_req, int_clear, i2c_req;
  logic [P-1:0] resetl, lpmode, modsell, gnt, present, ready, intlat;
  int           n_chk = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  taxi_qsfp_port_mgr #(
    .PORT_CNT(P), .DEBOUNCE_CYC(4), .RESET_CYC(3), .INIT_CYC(5),
    .MODSEL_SETUP_CYC(2), .CNT_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .eth_port_modprsl(modprsl), .eth_port_intl(intl),
    .eth_port_resetl(resetl), .eth_port_lpmode(lpmode), .eth_port_modsell(modsell),
    .cfg_lpmode(cfg_lpmode), .sw_reset_req(sw_reset_req), .int_clear(int_clear),
    .i2c_req(i2c_req), .i2c_gnt(gnt),
    .stat_present(present), .stat_ready(ready), .int_latched(intlat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int p, input int budget);
    int c = 0;
    while (ready[p] !== 1'b1 && c < budget) begin
      tick(1);
      c++;
    end
    chk($sformatf("ready%0d_wait", p), 32'(ready[p]), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_resetl"},  32'(resetl),  32'b00);
    chk({tag, "_lpmode"},  32'(lpmode),  32'b11);
    chk({tag, "_modsell"}, 32'(modsell), 32'b11);
    chk({tag, "_gnt"},     32'(gnt),     32'b00);
    chk({tag, "_present"}, 32'(present), 32'b00);
    chk({tag, "_ready"},   32'(ready),   32'b00);
    chk({tag, "_int"},     32'(intlat),  32'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic     seen;
    logic     exp_int, c, il, cl, syn;
    logic     hist[$];

    modprsl = '1; intl = '1; cfg_lpmode = '0;
    sw_reset_req = '0; int_clear = '0; i2c_req = '0;
    tick(3);
    chk_reset_vals("in_reset");
    rst_n = 1'b1;
    tick(20);
    chk_reset_vals("powerup");

    // insertion on port 0: 2 sync + 1 edge detect + 4 debounce cycles
    modprsl[0] = 1'b0;
    tick(6);
    chk("present0_early", 32'(present[0]), 32'd0);
    tick(1);
    chk("present0_rise", 32'(present[0]), 32'd1);
    chk("resetl0_at_rise", 32'(resetl[0]), 32'd0);
    tick(3);
    chk("resetl0_last_low", 32'(resetl[0]), 32'd0);
    tick(1);
    chk("resetl0_release", 32'(resetl[0]), 32'd1);
    chk("ready0_in_init", 32'(ready[0]), 32'd0);
    tick(4);
    chk("ready0_init_end", 32'(ready[0]), 32'd0);
    tick(1);
    chk("ready0_rise", 32'(ready[0]), 32'd1);
    chk("lpmode0_lag", 32'(lpmode[0]), 32'd1);
    tick(1);
    chk("lpmode0_cfg", 32'(lpmode[0]), 32'd0);

    // bounce on port 1 never qualifies
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      modprsl[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(1); seen |= present[1];
      tick(1); seen |= present[1];
    end
    modprsl[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1); seen |= present[1];
    end
    chk("bounce_present1", 32'(seen), 32'd0);
    chk("bounce_resetl1", 32'(resetl[1]), 32'd0);

    modprsl[1] = 1'b0;
    wait_ready(1, 40);

    // arbitration, port 0 first after reset
    i2c_req = 2'b11;
    tick(1);
    chk("arb_sel0_modsell", 32'(modsell), 32'b10);
    chk("arb_sel0_setup_gnt", 32'(gnt), 32'b00);
    tick(1);
    chk("arb_sel0_setup2_gnt", 32'(gnt), 32'b00);
    tick(1);
    chk("arb_gnt0", 32'(gnt), 32'b01);
    chk("arb_gnt0_modsell", 32'(modsell), 32'b10);
    tick(3);
    chk("arb_gnt0_hold", 32'(gnt), 32'b01);
    i2c_req = 2'b10;
    tick(1);
    chk("arb_release_gnt", 32'(gnt), 32'b00);
    chk("arb_release_modsell", 32'(modsell), 32'b11);
    tick(1);
    chk("arb_idle_modsell", 32'(modsell), 32'b11);
    tick(1);
    chk("arb_sel1_modsell", 32'(modsell), 32'b01);
    chk("arb_sel1_setup_gnt", 32'(gnt), 32'b00);
    tick(1);
    chk("arb_sel1_setup2_gnt", 32'(gnt), 32'b00);
    tick(1);
    chk("arb_gnt1", 32'(gnt), 32'b10);
    chk("arb_gnt1_modsell", 32'(modsell), 32'b01);

    // removal of port 1 while granted
    modprsl[1] = 1'b1;
    tick(7);
    chk("rm_present1_fall", 32'(present[1]), 32'd0);
    chk("rm_ready1_still", 32'(ready[1]), 32'd1);
    chk("rm_gnt_still", 32'(gnt), 32'b10);
    tick(1);
    chk("rm_ready1_drop", 32'(ready[1]), 32'd0);
    chk("rm_gnt_drop", 32'(gnt), 32'b00);
    chk("rm_modsell_held", 32'(modsell), 32'b01);
    chk("rm_resetl1", 32'(resetl[1]), 32'd0);
    tick(1);
    chk("rm_modsell_release", 32'(modsell), 32'b11);
    i2c_req = 2'b00;

    // interrupt latch on port 0
    intl[0] = 1'b0;
    tick(2);
    chk("int0_sync_delay", 32'(intlat), 32'b00);
    tick(1);
    chk("int0_set", 32'(intlat), 32'b01);
    int_clear[0] = 1'b1;
    tick(1);
    int_clear[0] = 1'b0;
    chk("int0_set_wins", 32'(intlat[0]), 32'd1);
    intl[0] = 1'b1;
    tick(3);
    chk("int0_sticky", 32'(intlat[0]), 32'd1);
    int_clear[0] = 1'b1;
    tick(1);
    int_clear[0] = 1'b0;
    chk("int0_cleared", 32'(intlat[0]), 32'd0);

    // sw reset with intl still low: latch forced off
    intl[0] = 1'b0;
    tick(3);
    chk("int0_reset_pre", 32'(intlat[0]), 32'd1);
    sw_reset_req[0] = 1'b1;
    tick(1);
    sw_reset_req[0] = 1'b0;
    chk("swrst_resetl0", 32'(resetl[0]), 32'd0);
    chk("swrst_int0", 32'(intlat[0]), 32'd0);
    chk("swrst_ready0", 32'(ready[0]), 32'd0);
    intl[0] = 1'b1;
    tick(2);
    chk("swrst_resetl0_hold", 32'(resetl[0]), 32'd0);
    tick(1);
    chk("swrst_resetl0_rel", 32'(resetl[0]), 32'd1);
    wait_ready(0, 20);
    tick(3);

    // randomized READY phase on port 0
    exp_int = 1'b0;
    hist.push_back(1'b1);
    hist.push_back(1'b1);
    for (int n = 0; n < 150; n++) begin
      c  = 1'($urandom_range(0, 1));
      il = ($urandom_range(0, 3) != 0);
      cl = 1'($urandom_range(0, 1));
      cfg_lpmode[0] = c;
      intl[0]       = il;
      int_clear[0]  = cl;
      i2c_req[0]    = 1'($urandom_range(0, 1));
      hist.push_back(il);
      tick(1);
      syn = hist[hist.size() - 3];
      if (!syn)    exp_int = 1'b1;
      else if (cl) exp_int = 1'b0;
      chk("rnd_int0", 32'(intlat[0]), 32'(exp_int));
      chk("rnd_lpmode0", 32'(lpmode[0]), 32'(c));
      chk("rnd_onehot",
          32'(($countones(~modsell) <= 1) && ($countones(gnt) <= 1) &&
              ((gnt & modsell) == '0) && ((gnt & ~ready) == '0)), 32'd1);
    end
    intl = '1; int_clear = '0; i2c_req = '0;
    tick(6);
    chk("final_gnt", 32'(gnt), 32'b00);
    chk("final_modsell", 32'(modsell), 32'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
